// File: rtl/dispatch_pkg.sv
// dispatch_pkg
// Shared types for the partial dispatch stage: the per-lane resource flag
// record carried alongside each held packet, and the bundle-occupancy
// state encoding used by the stage controller.
package dispatch_pkg;

    // Resources a single lane consumes besides its active-list entry.
    typedef struct packed {
        logic isLoad;
        logic isStore;
        logic needIq;
    } lane_flags_t;

    // Occupancy of the held bundle.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FULL    = 2'd1,
        ST_PARTIAL = 2'd2
    } disp_state_t;

    localparam int REASON_W  = 4;
    localparam int PCNT_W    = 16;

endpackage

// File: rtl/dispatch_fit.sv
// dispatch_fit
// Purely combinational prefix-fit check. Walks the pending lanes oldest
// first, accumulating AL/IQ/LQ/SQ demand, and grants every pending lane up
// to (not including) the first one whose cumulative demand exceeds any free
// count. Lanes after a blocked pending lane are never granted, even if they
// would fit on their own.
// Ports:
//   laneFlags_i   per-lane {isLoad,isStore,needIq}
//   pending_i     lanes still waiting to dispatch
//   alFree_i .. sqFree_i  free entries per structure (never negative)
//   fitMask_o     granted in-order prefix of pending lanes
//   blockReason_o {al,iq,lq,sq} overflow flags of the first blocked lane
module dispatch_fit
    import dispatch_pkg::*;
#(
    parameter int W      = 4,
    parameter int FREE_W = 8
) (
    input  lane_flags_t [W-1:0]        laneFlags_i,
    input  logic [W-1:0]               pending_i,
    input  logic [FREE_W-1:0]          alFree_i,
    input  logic [FREE_W-1:0]          iqFree_i,
    input  logic [FREE_W-1:0]          lqFree_i,
    input  logic [FREE_W-1:0]          sqFree_i,
    output logic [W-1:0]               fitMask_o,
    output logic [REASON_W-1:0]        blockReason_o
);

    // Extra headroom so the running demand can never wrap.
    localparam int CW = FREE_W + 4;

    logic [CW-1:0] al_use_s, iq_use_s, lq_use_s, sq_use_s;
    logic [CW-1:0] al_try_s, iq_try_s, lq_try_s, sq_try_s;
    logic          blocked_s;

    // Oldest-first accumulation of demand; stop granting at the first misfit.
    always_comb begin
        fitMask_o     = {W{1'b0}};
        blockReason_o = {REASON_W{1'b0}};
        al_use_s      = {CW{1'b0}};
        iq_use_s      = {CW{1'b0}};
        lq_use_s      = {CW{1'b0}};
        sq_use_s      = {CW{1'b0}};
        al_try_s      = {CW{1'b0}};
        iq_try_s      = {CW{1'b0}};
        lq_try_s      = {CW{1'b0}};
        sq_try_s      = {CW{1'b0}};
        blocked_s     = 1'b0;
        for (int i = 0; i < W; i++) begin
            al_try_s = al_use_s + CW'(1'b1);
            iq_try_s = iq_use_s + CW'(laneFlags_i[i].needIq);
            lq_try_s = lq_use_s + CW'(laneFlags_i[i].isLoad);
            sq_try_s = sq_use_s + CW'(laneFlags_i[i].isStore);
            if (pending_i[i] && !blocked_s) begin
                if ((al_try_s <= CW'(alFree_i)) && (iq_try_s <= CW'(iqFree_i)) &&
                    (lq_try_s <= CW'(lqFree_i)) && (sq_try_s <= CW'(sqFree_i))) begin
                    fitMask_o[i] = 1'b1;
                    al_use_s     = al_try_s;
                    iq_use_s     = iq_try_s;
                    lq_use_s     = lq_try_s;
                    sq_use_s     = sq_try_s;
                end else begin
                    blocked_s     = 1'b1;
                    blockReason_o = {al_try_s > CW'(alFree_i), iq_try_s > CW'(iqFree_i),
                                     lq_try_s > CW'(lqFree_i), sq_try_s > CW'(sqFree_i)};
                end
            end else begin
                // Idle lanes and lanes behind a blocked one are not granted.
                fitMask_o[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/partial_dispatch_stage.sv
// partial_dispatch_stage
// Holds one renamed bundle and dispatches its longest in-order prefix that
// fits the free AL/IQ/LQ/SQ space each cycle. Remaining lanes stay in place
// (no lane shifting) and the front end is stalled until they drain.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   laneActive_i, renameReady_i      bundle offer and its lane mask
//   disPacket_i, isLoad_i/isStore_i/needIq_i  packets and resource flags
//   alCnt_i, iqCnt_i, lqCnt_i, sqCnt_i        structure occupancies
//   flush_i, loadViolation_i         kill / block controls
//   dispValid_o, dispPacket_o        dispatched lanes and held packets
//   stallFrontEnd_o, stallReason_o   back-pressure and its cause
//   partialCnt_o                     saturating partial-dispatch cycle count
module partial_dispatch_stage
    import dispatch_pkg::*;
#(
    parameter int DISPATCH_WIDTH = 4,
    parameter int PKT_W          = 128,
    parameter int AL_SIZE        = 128,
    parameter int IQ_SIZE        = 64,
    parameter int LQ_SIZE        = 32,
    parameter int SQ_SIZE        = 32,
    // Reset value of the partial counter; nonzero only to reach saturation quickly.
    parameter logic [15:0] PARTIAL_CNT_INIT = 16'h0000
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [DISPATCH_WIDTH-1:0]            laneActive_i,
    input  logic                                 renameReady_i,
    input  logic [DISPATCH_WIDTH-1:0][PKT_W-1:0] disPacket_i,
    input  logic [DISPATCH_WIDTH-1:0]            isLoad_i,
    input  logic [DISPATCH_WIDTH-1:0]            isStore_i,
    input  logic [DISPATCH_WIDTH-1:0]            needIq_i,
    input  logic [$clog2(AL_SIZE):0]             alCnt_i,
    input  logic [$clog2(IQ_SIZE):0]             iqCnt_i,
    input  logic [$clog2(LQ_SIZE):0]             lqCnt_i,
    input  logic [$clog2(SQ_SIZE):0]             sqCnt_i,
    input  logic                                 flush_i,
    input  logic                                 loadViolation_i,
    output logic [DISPATCH_WIDTH-1:0]            dispValid_o,
    output logic [DISPATCH_WIDTH-1:0][PKT_W-1:0] dispPacket_o,
    output logic                                 stallFrontEnd_o,
    output logic [REASON_W-1:0]                  stallReason_o,
    output logic [PCNT_W-1:0]                    partialCnt_o
);

    localparam int W     = DISPATCH_WIDTH;
    localparam int AL_W  = $clog2(AL_SIZE) + 1;
    localparam int IQ_W  = $clog2(IQ_SIZE) + 1;
    localparam int LQ_W  = $clog2(LQ_SIZE) + 1;
    localparam int SQ_W  = $clog2(SQ_SIZE) + 1;
    localparam int M1_W  = (AL_W > IQ_W) ? AL_W : IQ_W;
    localparam int M2_W  = (LQ_W > SQ_W) ? LQ_W : SQ_W;
    localparam int FREE_W = (M1_W > M2_W) ? M1_W : M2_W;

    // Free entries, clamped at zero if the reported count ever exceeds capacity.
    function automatic logic [FREE_W-1:0] free_space(input int size, input int cnt);
        if (cnt >= size) begin
            free_space = {FREE_W{1'b0}};
        end else begin
            free_space = FREE_W'(size - cnt);
        end
    endfunction

    disp_state_t            state_r, next_state_s;
    logic [W-1:0]           pending_r, pending_next_s;
    lane_flags_t [W-1:0]    flags_r, in_flags_s;
    logic [W-1:0][PKT_W-1:0] pkt_r;
    logic [PCNT_W-1:0]      partial_cnt_r;

    logic [FREE_W-1:0]      al_free_s, iq_free_s, lq_free_s, sq_free_s;
    logic [W-1:0]           fit_mask_s, disp_valid_s, remain_s;
    logic [REASON_W-1:0]    fit_reason_s, reason_s;
    logic                   stall_s, capture_s, partial_s;

    // Free space per structure and incoming lane flag packing.
    always_comb begin
        al_free_s  = free_space(AL_SIZE, int'(alCnt_i));
        iq_free_s  = free_space(IQ_SIZE, int'(iqCnt_i));
        lq_free_s  = free_space(LQ_SIZE, int'(lqCnt_i));
        sq_free_s  = free_space(SQ_SIZE, int'(sqCnt_i));
        in_flags_s = {W{3'b000}};
        for (int i = 0; i < W; i++) begin
            in_flags_s[i].isLoad  = isLoad_i[i];
            in_flags_s[i].isStore = isStore_i[i];
            in_flags_s[i].needIq  = needIq_i[i];
        end
    end

    dispatch_fit #(
        .W      (W),
        .FREE_W (FREE_W)
    ) u_fit (
        .laneFlags_i   (flags_r),
        .pending_i     (pending_r),
        .alFree_i      (al_free_s),
        .iqFree_i      (iq_free_s),
        .lqFree_i      (lq_free_s),
        .sqFree_i      (sq_free_s),
        .fitMask_o     (fit_mask_s),
        .blockReason_o (fit_reason_s)
    );

    // Dispatch gating, stall, capture and next pending mask.
    always_comb begin
        if (flush_i || loadViolation_i || reset) begin
            disp_valid_s = {W{1'b0}};
        end else begin
            disp_valid_s = fit_mask_s;
        end
        remain_s = pending_r & ~disp_valid_s;
        // A bundle that fully drains this cycle frees rename to hand over the next one.
        stall_s   = !reset && (|pending_r) && (|remain_s);
        if (stall_s && !loadViolation_i) begin
            reason_s = fit_reason_s;
        end else begin
            reason_s = {REASON_W{1'b0}};
        end
        capture_s = renameReady_i && !stall_s && !flush_i && !reset;
        partial_s = (|disp_valid_s) && (|remain_s);
        if (flush_i) begin
            pending_next_s = {W{1'b0}};
        end else if (capture_s) begin
            pending_next_s = laneActive_i;
        end else begin
            pending_next_s = remain_s;
        end
    end

    // Bundle occupancy next-state.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (capture_s && (|laneActive_i)) begin
                    next_state_s = ST_FULL;
                end else begin
                    next_state_s = ST_EMPTY;
                end
            end
            ST_FULL, ST_PARTIAL: begin
                if (flush_i) begin
                    next_state_s = ST_EMPTY;
                end else if (~|remain_s) begin
                    if (capture_s && (|laneActive_i)) begin
                        next_state_s = ST_FULL;
                    end else begin
                        next_state_s = ST_EMPTY;
                    end
                end else if (|disp_valid_s) begin
                    next_state_s = ST_PARTIAL;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: next_state_s = ST_EMPTY;
        endcase
    end

    // Control state: occupancy, pending mask and partial-dispatch counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_EMPTY;
            pending_r     <= {W{1'b0}};
            partial_cnt_r <= PARTIAL_CNT_INIT;
        end else begin
            state_r   <= next_state_s;
            pending_r <= pending_next_s;
            if (partial_s && (partial_cnt_r != 16'hFFFF)) begin
                partial_cnt_r <= partial_cnt_r + 16'd1;
            end
        end
    end

    // Packet and flag storage; valid only under the pending mask, so not reset.
    always_ff @(posedge clk) begin
        if (capture_s) begin
            pkt_r   <= disPacket_i;
            flags_r <= in_flags_s;
        end
    end

    assign dispValid_o     = disp_valid_s;
    assign dispPacket_o    = pkt_r;
    assign stallFrontEnd_o = stall_s;
    assign stallReason_o   = reason_s;
    assign partialCnt_o    = partial_cnt_r;

endmodule

// File: tb/tb_partial_dispatch_stage.sv
// Bench for partial_dispatch_stage: directed scenarios followed by random
// traffic, every cycle compared against a lane-list reference model.
module tb_partial_dispatch_stage;

    localparam logic [15:0] SAT_INIT = 16'hFFFA;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       laneActive, isLoad, isStore, needIq;
    logic             renameReady, flush, loadViolation;
    logic [3:0][127:0] disPacket;
    logic [7:0]       alCnt;
    logic [6:0]       iqCnt;
    logic [5:0]       lqCnt, sqCnt;
    logic [3:0]       dispValid, dispValid2;
    logic [3:0][127:0] dispPacket, dispPacket2;
    logic             stall, stall2;
    logic [3:0]       reason, reason2;
    logic [15:0]      partialCnt, partialCnt2;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: which lanes still wait, plus their payloads.
    bit   [3:0]   m_pend;
    bit   [2:0]   m_flags [4];   // {ld, st, iq}
    logic [127:0] m_pkt [4];
    int           m_cnt, m_cnt2, n_part;
    bit           m_cnt_known = 1'b0;

    logic [3:0]  last_valid, last_reason;
    logic        last_stall;
    logic [15:0] last_cnt, last_cnt2;

    always #5 clk = ~clk;

    partial_dispatch_stage dut (
        .clk(clk), .reset(reset), .laneActive_i(laneActive), .renameReady_i(renameReady),
        .disPacket_i(disPacket), .isLoad_i(isLoad), .isStore_i(isStore), .needIq_i(needIq),
        .alCnt_i(alCnt), .iqCnt_i(iqCnt), .lqCnt_i(lqCnt), .sqCnt_i(sqCnt),
        .flush_i(flush), .loadViolation_i(loadViolation), .dispValid_o(dispValid),
        .dispPacket_o(dispPacket), .stallFrontEnd_o(stall), .stallReason_o(reason),
        .partialCnt_o(partialCnt)
    );

    partial_dispatch_stage #(.PARTIAL_CNT_INIT(SAT_INIT)) dut_sat (
        .clk(clk), .reset(reset), .laneActive_i(laneActive), .renameReady_i(renameReady),
        .disPacket_i(disPacket), .isLoad_i(isLoad), .isStore_i(isStore), .needIq_i(needIq),
        .alCnt_i(alCnt), .iqCnt_i(iqCnt), .lqCnt_i(lqCnt), .sqCnt_i(sqCnt),
        .flush_i(flush), .loadViolation_i(loadViolation), .dispValid_o(dispValid2),
        .dispPacket_o(dispPacket2), .stallFrontEnd_o(stall2), .stallReason_o(reason2),
        .partialCnt_o(partialCnt2)
    );

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int free_of(input int size, input int cnt);
        return (cnt >= size) ? 0 : size - cnt;
    endfunction

    // One clock: check outputs against the model at the falling edge, then
    // advance the model at the rising edge.
    task automatic step();
        int fr [4];
        int used [4];
        int need [4];
        bit stop;
        logic [3:0] pre, ev, fit_rsn, er;
        bit es, part;
        @(negedge clk);
        fr[0] = free_of(128, int'(alCnt));
        fr[1] = free_of(64,  int'(iqCnt));
        fr[2] = free_of(32,  int'(lqCnt));
        fr[3] = free_of(32,  int'(sqCnt));
        used = '{0, 0, 0, 0};
        pre = 4'b0000; fit_rsn = 4'b0000; stop = 1'b0;
        for (int l = 0; l < 4; l++) begin
            if (m_pend[l] && !stop) begin
                need[0] = used[0] + 1;
                need[1] = used[1] + int'(m_flags[l][0]);
                need[2] = used[2] + int'(m_flags[l][2]);
                need[3] = used[3] + int'(m_flags[l][1]);
                if (need[0] <= fr[0] && need[1] <= fr[1] && need[2] <= fr[2] && need[3] <= fr[3]) begin
                    pre[l] = 1'b1;
                    used = need;
                end else begin
                    stop = 1'b1;
                    fit_rsn = {need[0] > fr[0], need[1] > fr[1], need[2] > fr[2], need[3] > fr[3]};
                end
            end
        end
        ev = (flush || loadViolation || reset) ? 4'b0000 : pre;
        es = !reset && (m_pend != 4'b0000) && ((m_pend & ~ev) != 4'b0000);
        er = (es && !loadViolation) ? fit_rsn : 4'b0000;
        part = (ev != 4'b0000) && ((m_pend & ~ev) != 4'b0000);

        check_val("dispValid", dispValid, ev);
        check_val("stall", stall, es);
        check_val("stallReason", reason, er);
        check_val("dispValid_sat", dispValid2, ev);
        check_val("stall_sat", stall2, es);
        for (int l = 0; l < 4; l++) begin
            if (ev[l]) check_val("dispPacket", dispPacket[l], m_pkt[l]);
        end
        if (m_cnt_known) begin
            check_val("partialCnt", partialCnt, m_cnt);
            check_val("partialCnt_sat", partialCnt2, m_cnt2);
        end
        last_valid = dispValid; last_stall = stall; last_reason = reason;
        last_cnt = partialCnt; last_cnt2 = partialCnt2;

        @(posedge clk);
        if (reset) begin
            m_pend = 4'b0000; m_cnt = 0; m_cnt2 = int'(SAT_INIT); n_part = 0; m_cnt_known = 1'b1;
        end else begin
            if (part) begin
                n_part++;
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 65535) m_cnt2++;
            end
            if (flush) begin
                m_pend = 4'b0000;
            end else if (renameReady && !es) begin
                m_pend = laneActive;
                for (int l = 0; l < 4; l++) begin
                    m_flags[l] = {isLoad[l], isStore[l], needIq[l]};
                    m_pkt[l] = disPacket[l];
                end
            end else begin
                m_pend = m_pend & ~ev;
            end
        end
        #1;
    endtask

    task automatic set_idle();
        renameReady = 1'b0; flush = 1'b0; loadViolation = 1'b0; reset = 1'b0;
        laneActive = 4'hF; isLoad = 4'h0; isStore = 4'h0; needIq = 4'h0;
        alCnt = 8'd0; iqCnt = 7'd0; lqCnt = 6'd0; sqCnt = 6'd0;
    endtask

    task automatic new_packets();
        for (int l = 0; l < 4; l++) disPacket[l] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        set_idle();
        new_packets();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        check_val("rst_valid", last_valid, 4'b0000);
        check_val("rst_stall", last_stall, 1'b0);
        check_val("rst_reason", last_reason, 4'b0000);
        check_val("rst_cnt", last_cnt, 16'h0000);

        // Four ALU lanes, everything free.
        renameReady = 1'b1; new_packets(); step();
        renameReady = 1'b0; step();
        check_val("full_valid", last_valid, 4'b1111);
        check_val("full_stall", last_stall, 1'b0);

        // AL free 2, then 4.
        renameReady = 1'b1; new_packets(); step();
        renameReady = 1'b0; alCnt = 8'd126; step();
        check_val("al2_valid", last_valid, 4'b0011);
        check_val("al2_reason", last_reason, 4'b1000);
        check_val("al2_stall", last_stall, 1'b1);
        alCnt = 8'd124; step();
        check_val("al4_valid", last_valid, 4'b1100);
        check_val("al4_stall", last_stall, 1'b0);
        check_val("al4_cnt", last_cnt, 16'd1);

        // {ld,st,ld,ALU} with one LQ entry free: lane 3 held behind lane 2.
        alCnt = 8'd0; isLoad = 4'b0101; isStore = 4'b0010;
        renameReady = 1'b1; new_packets(); step();
        renameReady = 1'b0; lqCnt = 6'd31; step();
        check_val("lq_valid", last_valid, 4'b0011);
        check_val("lq_reason", last_reason, 4'b0010);

        // Flush while partial, rename offering.
        flush = 1'b1; renameReady = 1'b1; new_packets(); step();
        check_val("flush_valid", last_valid, 4'b0000);
        flush = 1'b0; renameReady = 1'b0; lqCnt = 6'd0; step();
        check_val("postflush_valid", last_valid, 4'b0000);
        check_val("postflush_stall", last_stall, 1'b0);

        // Lane mask 0011, then a load-violation pulse.
        isLoad = 4'h0; isStore = 4'h0; laneActive = 4'b0011;
        renameReady = 1'b1; new_packets(); step();
        laneActive = 4'hF; renameReady = 1'b0; step();
        check_val("mask_valid", last_valid, 4'b0011);
        renameReady = 1'b1; new_packets(); step();
        renameReady = 1'b0; loadViolation = 1'b1; step();
        check_val("lv_valid", last_valid, 4'b0000);
        check_val("lv_reason", last_reason, 4'b0000);
        loadViolation = 1'b0; step();
        check_val("lv_resume", last_valid, 4'b1111);

        // Reset while partial.
        renameReady = 1'b1; new_packets(); step();
        renameReady = 1'b0; alCnt = 8'd127; step();
        check_val("rp_valid", last_valid, 4'b0001);
        reset = 1'b1; step();
        check_val("rp_rst_valid", last_valid, 4'b0000);
        reset = 1'b0; alCnt = 8'd0; step();
        check_val("rp_after_valid", last_valid, 4'b0000);
        check_val("rp_after_stall", last_stall, 1'b0);

        // Random traffic biased toward nearly full structures.
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 299) == 0);
            flush         = ($urandom_range(0, 29) == 0);
            loadViolation = ($urandom_range(0, 19) == 0);
            renameReady   = ($urandom_range(0, 3) != 0);
            laneActive    = 4'($urandom);
            isLoad        = 4'($urandom);
            isStore       = 4'($urandom);
            needIq        = 4'($urandom);
            alCnt         = 8'($urandom_range(120, 131));
            iqCnt         = 7'($urandom_range(57, 66));
            lqCnt         = 6'($urandom_range(27, 34));
            sqCnt         = 6'($urandom_range(27, 34));
            new_packets();
            step();
        end

        set_idle(); step();
        if (n_part >= 8) check_val("sat_hold", last_cnt2, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
